// File: rtl/message_loader.sv
// message_loader
//   Upstream feeder for the 4-digit rotating seven-segment display. Holds a
//   16 x 4-bit message memory, loads characters from the slide switches on a
//   debounced write button, clears the whole message on a debounced clear
//   button, and presents four consecutive characters starting at the
//   display's rotation pointer.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   sw        character to write
//   btn_wr    raw write pushbutton (active-high, asynchronous)
//   btn_clr   raw clear pushbutton (active-high, asynchronous)
//   rd_base   rotation pointer from the display stage
//   char0..3  mem[rd_base + N mod 16], registered
//   wr_ptr    index of the next entry to be written
//   busy      high while a clear sweep is in progress
module message_loader #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
    parameter logic [3:0]  CLEAR_VAL       = 4'hF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       btn_wr,
    input  logic       btn_clr,
    input  logic [3:0] rd_base,
    output logic [3:0] char0,
    output logic [3:0] char1,
    output logic [3:0] char2,
    output logic [3:0] char3,
    output logic [3:0] wr_ptr,
    output logic       busy
);

    localparam logic IDLE  = 1'b0;
    localparam logic CLEAR = 1'b1;

    // Bit 0 is the write button, bit 1 the clear button.
    logic [1:0] btn_raw;
    logic [1:0] pulse_vec;
    logic       wr_pulse;
    logic       clr_pulse;

    assign btn_raw   = {btn_clr, btn_wr};
    assign wr_pulse  = pulse_vec[0];
    assign clr_pulse = pulse_vec[1];

    // Button conditioning: 2-flop synchronizer, consecutive-sample debouncer,
    // registered rising-edge pulse. Press-to-pulse latency is
    // DEBOUNCE_CYCLES + 3 clocks.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic        meta_reg;
            logic        sync_reg;
            logic        db_reg;
            logic        db_d_reg;
            logic        pulse_reg;
            logic [19:0] cnt_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    meta_reg  <= 1'b0;
                    sync_reg  <= 1'b0;
                    db_reg    <= 1'b0;
                    db_d_reg  <= 1'b0;
                    pulse_reg <= 1'b0;
                    cnt_reg   <= 20'd0;
                end else begin
                    meta_reg  <= btn_raw[gi];
                    sync_reg  <= meta_reg;
                    db_d_reg  <= db_reg;
                    pulse_reg <= db_reg & ~db_d_reg;
                    // Any sample that agrees with the accepted level restarts
                    // the run, so bounces never accumulate.
                    if (sync_reg != db_reg) begin
                        if (cnt_reg == DEBOUNCE_CYCLES - 20'd1) begin
                            db_reg  <= sync_reg;
                            cnt_reg <= 20'd0;
                        end else begin
                            cnt_reg <= cnt_reg + 20'd1;
                        end
                    end else begin
                        cnt_reg <= 20'd0;
                    end
                end
            end

            assign pulse_vec[gi] = pulse_reg;
        end
    endgenerate

    // Control FSM
    logic       state_reg;
    logic [3:0] clr_idx_reg;
    logic [3:0] wr_ptr_reg;
    logic       busy_reg;

    // Single memory write port shared by the load path and the clear sweep.
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [3:0] mem_data;

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = wr_ptr_reg;
        mem_data = sw;
        if (state_reg == CLEAR) begin
            mem_we   = 1'b1;
            mem_addr = clr_idx_reg;
            mem_data = CLEAR_VAL;
        end else if (!clr_pulse && wr_pulse) begin
            // A clear in the same cycle wins and the write is dropped.
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            clr_idx_reg <= 4'd0;
            wr_ptr_reg  <= 4'd0;
            busy_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (clr_pulse) begin
                        state_reg   <= CLEAR;
                        clr_idx_reg <= 4'd0;
                        busy_reg    <= 1'b1;
                    end else if (wr_pulse) begin
                        wr_ptr_reg <= wr_ptr_reg + 4'd1;
                    end
                end
                default: begin
                    // Pulses are ignored here: writes are dropped and a
                    // second clear does not restart the sweep.
                    clr_idx_reg <= clr_idx_reg + 4'd1;
                    if (clr_idx_reg == 4'd15) begin
                        state_reg  <= IDLE;
                        busy_reg   <= 1'b0;
                        wr_ptr_reg <= 4'd0;
                    end
                end
            endcase
        end
    end

    // Message memory. Kept in flops: reset must restore the identity pattern
    // and four entries are read every cycle.
    logic [15:0][3:0] mem_flat;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_mem
            logic [3:0] entry_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    entry_reg <= 4'(gi);
                end else if (mem_we && mem_addr == 4'(gi)) begin
                    entry_reg <= mem_data;
                end
            end

            assign mem_flat[gi] = entry_reg;
        end
    endgenerate

    // Read window; 4-bit sums wrap modulo 16.
    logic [3:0] rd_addr1;
    logic [3:0] rd_addr2;
    logic [3:0] rd_addr3;
    logic [3:0] char0_reg;
    logic [3:0] char1_reg;
    logic [3:0] char2_reg;
    logic [3:0] char3_reg;

    assign rd_addr1 = rd_base + 4'd1;
    assign rd_addr2 = rd_base + 4'd2;
    assign rd_addr3 = rd_base + 4'd3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            char0_reg <= 4'd0;
            char1_reg <= 4'd1;
            char2_reg <= 4'd2;
            char3_reg <= 4'd3;
        end else begin
            char0_reg <= mem_flat[rd_base];
            char1_reg <= mem_flat[rd_addr1];
            char2_reg <= mem_flat[rd_addr2];
            char3_reg <= mem_flat[rd_addr3];
        end
    end

    assign char0  = char0_reg;
    assign char1  = char1_reg;
    assign char2  = char2_reg;
    assign char3  = char3_reg;
    assign wr_ptr = wr_ptr_reg;
    assign busy   = busy_reg;

endmodule

// File: doc/message_loader.md
Name: message_loader

Overview:
- Upstream feeder for the 4-digit rotating seven-segment display stage.
- Holds the 16-entry x 4-bit message memory that the display stage scrolls through.
- The user loads characters from four slide switches via a debounced write button, and clears the message via a debounced clear button.
- Presents the four characters starting at the display's rotation pointer, registered, to the anode/decoder stage.

Parameters:
- DEBOUNCE_CYCLES, 20'd1000000, number of consecutive stable samples needed before a button level is accepted (bench uses 4).
- CLEAR_VAL, 4'hF, character value written to every entry by a clear sweep.

Ports:
- clk  input  1  system clock; all logic on its rising edge
- reset  input  1  asynchronous, active-low reset
- sw  input  4  character to write (raw switches, quasi-static)
- btn_wr  input  1  raw write pushbutton, active-high, asynchronous to clk
- btn_clr  input  1  raw clear pushbutton, active-high, asynchronous to clk
- rd_base  input  4  rotation pointer from the display stage
- char0  output  4  mem[rd_base], registered
- char1  output  4  mem[rd_base+1 mod 16], registered
- char2  output  4  mem[rd_base+2 mod 16], registered
- char3  output  4  mem[rd_base+3 mod 16], registered
- wr_ptr  output  4  index of the next entry to be written
- busy  output  1  high while a clear sweep is in progress

Behaviour:
- Reset (reset=0, async):
  - mem[i]=i for i=0..15.
  - wr_ptr=0, busy=0, FSM=IDLE.
  - char0..3=0,1,2,3.
  - Synchronizers and debouncers at 0, counters at 0.
- Button path, per button:
  - 2-flop synchronizer.
  - The debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive clocks. Any bounce restarts the count.
  - Rising edge of the debounced level produces a one-cycle pulse (wr_pulse or clr_pulse).
  - Latency from a clean press to the pulse is DEBOUNCE_CYCLES+3 clocks.
  - Release generates no pulse.
- Write, in IDLE:
  - On wr_pulse: mem[wr_ptr]<=sw and wr_ptr<=wr_ptr+1.
  - wr_ptr wraps 15->0 and silently overwrites; there is no full flag.
- Clear FSM, states IDLE and CLEAR:
  - IDLE->CLEAR on clr_pulse: clr_idx<=0, busy<=1.
  - In CLEAR, each cycle: mem[clr_idx]<=CLEAR_VAL, clr_idx++.
  - After writing index 15: ->IDLE, busy<=0, wr_ptr<=0.
  - A sweep is exactly 16 cycles.
  - busy rises the cycle after clr_pulse and falls the cycle after the index-15 write.
- Simultaneous events:
  - wr_pulse and clr_pulse in the same cycle (IDLE): clear wins, write dropped, wr_ptr unchanged until the sweep resets it to 0.
  - wr_pulse during CLEAR: dropped (not queued).
  - clr_pulse during CLEAR: ignored; the sweep is not restarted.
- Read:
  - charN<=mem[(rd_base+N) mod 16] every cycle; 4-bit addition wraps naturally.
  - Latency is 1 clock from rd_base.
  - Read and write to the same entry in the same cycle: char shows the old value that cycle and the new value the next.
  - Reads continue during CLEAR and show partially-cleared contents.
- Reset mid-sweep or mid-debounce: immediate return to reset state; memory is re-initialised to identity.

Test Plan:
- Reset then rd_base=0 -> after 1 clk, char0..3=0,1,2,3; rd_base=14 -> char0..3=E,F,0,1; wr_ptr=0, busy=0.
- DEBOUNCE_CYCLES=4. sw=A, btn_wr high 10 clks -> exactly one write:
  - mem[0]=A, wr_ptr=1.
  - With rd_base=0, char0=A.
  - Release generates no second write.
- btn_wr toggled every 2 clks for 20 clks, then low -> no write; wr_ptr stays 0.
- 17 clean presses with sw=5 ->
  - wr_ptr wraps to 1.
  - mem[0]=5 (overwritten), all entries 5.
- Press btn_clr ->
  - busy high exactly 16 clks.
  - Afterwards every entry=F and wr_ptr=0.
  - A btn_wr press whose pulse lands during busy is dropped.
  - A second btn_clr during busy does not extend busy.
- Assert reset low mid-sweep (clr_idx=7) -> busy=0 immediately; after release, char0..3 for rd_base=4 = 4,5,6,7.
